// File: rtl/bist_pkg.sv
// Shared constants for the BIST sequencer: state encoding and default widths.
package bist_pkg;

  // Default widths of the cycle counter and of the MISR signature.
  localparam int DEF_CNT_W = 10;
  localparam int DEF_SIG_W = 16;

  // Sequencer state encoding.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

endpackage

// File: rtl/bist_run_counter.sv
// Per-pass cycle counter: counts RUN cycles, flags the last one, and produces
// the registered pattern toggle aligned with the running output.
module bist_run_counter
  import bist_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,     // current state is INIT
  input  logic             advance,   // current state is RUN
  input  logic             run_next,  // next state is RUN
  input  logic [CNT_W-1:0] n_lat,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             toggle
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last_val;

  assign last_val = n_lat - CNT_W'(1);
  assign last     = (cnt == last_val);

  // Next count: cleared in INIT, advanced in RUN, saturating at the last cycle.
  always_comb begin
    cnt_d = cnt;
    if (clear) begin
      cnt_d = '0;
    end else if (advance && !last) begin
      cnt_d = cnt + CNT_W'(1);
    end else begin
      cnt_d = cnt;
    end
  end

  // Counter and toggle registers; toggle is computed from next-cycle values so it lines up with running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      toggle <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      toggle <= run_next & ~cnt_d[0] & (cnt_d != last_val);
    end
  end

endmodule

// File: rtl/bist_sequencer.sv
// Multi-pass BIST sequencer: on a start edge runs NPASS passes of N cycles,
// checks the MISR signature after each pass and reports sticky end/pass flags.
// Optional feature macro: BIST_ABORT_EN adds the abort port and early-finish logic.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEF_NCYCLES = 650,
  parameter int NPASS       = 2,
  parameter int SIG_W       = DEF_SIG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       ncycles_cfg,
  input  logic [SIG_W-1:0]       sig_in,
  input  logic [SIG_W-1:0]       golden_sig,
`ifdef BIST_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   init,
  output logic                   running,
  output logic                   toggle,
  output logic                   finish,
  output logic [$clog2(NPASS):0] pass_idx,
  output logic                   bist_end,
  output logic                   bist_pass
);

  localparam int PW = $clog2(NPASS) + 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

  logic [2:0]       state;
  logic [2:0]       state_d;
  logic             start_q;
  logic             accept;
  logic             fail;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             init_d;
  logic             running_d;
  logic             finish_d;
  logic             force_finish;

  assign accept = start & ~start_q & (state == S_IDLE);

`ifdef BIST_ABORT_EN
  // FINISH is excluded so a held abort cannot trap the sequencer there.
  assign force_finish = abort & (state != S_IDLE) & (state != S_FINISH);
`else
  assign force_finish = 1'b0;
`endif

  bist_run_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == S_INIT),
    .advance  (state == S_RUN),
    .run_next (state_d == S_RUN),
    .n_lat    (n_lat),
    .cnt      (cnt),
    .last     (last),
    .toggle   (toggle)
  );

  // State register and start edge detector; start_q tracks start even during reset.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (accept) state_d = S_START; else state_d = S_IDLE;
      S_START:  state_d = S_INIT;
      S_INIT:   state_d = S_RUN;
      S_RUN:    if (last) state_d = S_CHECK; else state_d = S_RUN;
      S_CHECK:  if (pass_idx < LAST_PASS) state_d = S_INIT; else state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (force_finish) begin
      state_d = S_FINISH;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so the registered outputs align with the state.
  always_comb begin
    init_d    = (state_d == S_INIT);
    running_d = (state_d == S_RUN);
    finish_d  = (state_d == S_FINISH);
  end

  // Registered strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      init    <= 1'b0;
      running <= 1'b0;
      finish  <= 1'b0;
    end else begin
      init    <= init_d;
      running <= running_d;
      finish  <= finish_d;
    end
  end

  // Run length latch, pass index, sticky fail flag and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lat     <= '0;
      pass_idx  <= '0;
      fail      <= 1'b0;
      bist_end  <= 1'b0;
      bist_pass <= 1'b0;
    end else if (accept) begin
      n_lat     <= (ncycles_cfg == '0) ? CNT_W'(DEF_NCYCLES) : ncycles_cfg;
      pass_idx  <= '0;
      fail      <= 1'b0;
      bist_end  <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      if (state == S_CHECK) begin
        fail <= fail | (sig_in != golden_sig);
      end
      if ((state == S_CHECK) && (state_d == S_INIT)) begin
        pass_idx <= pass_idx + PW'(1);
      end
      if (force_finish) begin
        fail <= 1'b1;
      end
      if (state == S_FINISH) begin
        bist_end  <= 1'b1;
        bist_pass <= ~fail;
      end
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: randomized runs compared cycle by
// cycle against a timeline model derived from the pass/cycle arithmetic.
module tb_bist_sequencer;

  localparam int CNT_W = 10;
  localparam int DEF_N = 650;
  localparam int NPASS = 2;
  localparam int SIG_W = 16;
  localparam int PW    = $clog2(NPASS) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] ncycles_cfg;
  logic [SIG_W-1:0] sig_in;
  logic [SIG_W-1:0] golden_sig;
  logic             abort;
  logic             init;
  logic             running;
  logic             toggle;
  logic             finish;
  logic [PW-1:0]    pass_idx;
  logic             bist_end;
  logic             bist_pass;

  int n_cmp = 0;
  int n_mis = 0;

  bist_sequencer #(
    .CNT_W       (CNT_W),
    .DEF_NCYCLES (DEF_N),
    .NPASS       (NPASS),
    .SIG_W       (SIG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ncycles_cfg (ncycles_cfg),
    .sig_in      (sig_in),
    .golden_sig  (golden_sig),
`ifdef BIST_ABORT_EN
    .abort       (abort),
`endif
    .init        (init),
    .running     (running),
    .toggle      (toggle),
    .finish      (finish),
    .pass_idx    (pass_idx),
    .bist_end    (bist_end),
    .bist_pass   (bist_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph, input logic e_init, input logic e_run,
                               input logic e_tog, input logic e_fin, input int e_pidx,
                               input logic e_end, input logic e_pass);
    check({ph, ".init"},      32'(init),      32'(e_init));
    check({ph, ".running"},   32'(running),   32'(e_run));
    check({ph, ".toggle"},    32'(toggle),    32'(e_tog));
    check({ph, ".finish"},    32'(finish),    32'(e_fin));
    check({ph, ".pass_idx"},  32'(pass_idx),  32'(e_pidx));
    check({ph, ".bist_end"},  32'(bist_end),  32'(e_end));
    check({ph, ".bist_pass"}, 32'(bist_pass), 32'(e_pass));
  endtask

  // One BIST run. Cycle j = number of clock edges since (and including) the accept edge.
  // Timeline: j=1 START, then NPASS blocks of (INIT, N x RUN, CHECK), then FINISH, then results.
  task automatic run_bist(input int cfg, input logic [NPASS-1:0] mism,
                          input int reset_at, input int abort_at);
    int n, jf, last_p, p, r, c;
    logic aborted;
    logic e_init, e_run, e_tog, e_fin, e_end, e_pass;
    int e_pidx;
    logic [SIG_W-1:0] gold [NPASS];
    logic [SIG_W-1:0] seen [NPASS];
    n       = (cfg == 0) ? DEF_N : cfg;
    aborted = (abort_at > 0);
    jf      = aborted ? abort_at + 1 : 2 + NPASS * (n + 2);
    last_p  = aborted ? (abort_at - 2) / (n + 2) : NPASS - 1;
    for (int k = 0; k < NPASS; k++) begin
      gold[k] = SIG_W'($urandom);
      seen[k] = mism[k] ? (gold[k] ^ SIG_W'($urandom_range(1, 65535))) : gold[k];
    end
    ncycles_cfg = CNT_W'(cfg);
    golden_sig  = gold[0];
    sig_in      = seen[0];
    start       = 1'b1;
    for (int j = 1; j <= jf + 1; j++) begin
      @(posedge clk);
      #1;
      e_init = 1'b0; e_run = 1'b0; e_tog = 1'b0; e_fin = 1'b0;
      e_end = 1'b0; e_pass = 1'b0; e_pidx = 0;
      if (reset_at > 0 && j == reset_at + 1) begin
        check_outputs("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        break;
      end
      if (j >= 2 && j < jf) begin
        p      = (j - 2) / (n + 2);
        r      = (j - 2) % (n + 2);
        c      = r - 1;
        e_pidx = p;
        e_init = (r == 0);
        e_run  = (r >= 1) && (r <= n);
        e_tog  = e_run && (c % 2 == 0) && (c != n - 1);
      end else if (j == jf) begin
        e_fin  = 1'b1;
        e_pidx = last_p;
      end else if (j == jf + 1) begin
        e_end  = 1'b1;
        e_pass = (mism == '0) && !aborted;
        e_pidx = last_p;
      end
      check_outputs("run", e_init, e_run, e_tog, e_fin, e_pidx, e_end, e_pass);
      // Drive the next cycle: extra start edges and config changes must be ignored mid-run.
      reset = (j == reset_at);
      abort = aborted && (j == abort_at);
      if (j >= jf - 1 || j == reset_at) start = 1'b0;
      else start = 1'($urandom_range(0, 1));
      ncycles_cfg = CNT_W'($urandom);
      p = (j >= 2) ? (j - 2) / (n + 2) : 0;
      if (p > NPASS - 1) p = NPASS - 1;
      golden_sig = gold[p];
      sig_in     = seen[p];
    end
    reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold.bist_end",  32'(bist_end),  (reset_at > 0) ? 32'd0 : 32'd1);
    check("hold.bist_pass", 32'(bist_pass), (reset_at > 0 || aborted || mism != '0) ? 32'd0 : 32'd1);
    check("hold.running",   32'(running),   32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    ncycles_cfg = '0;
    sig_in      = '0;
    golden_sig  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Short run, all signatures match.
    run_bist(4, 2'b00, 0, 0);
    // Default run length.
    run_bist(0, 2'b00, 0, 0);
    // Mismatch in pass 0 only; pass 1 still runs.
    run_bist(5, 2'b01, 0, 0);
    // Reset at RUN cnt=2 of pass 0.
    run_bist(8, 2'b00, 5, 0);

    // Start rising together with reset and held through release: no run.
    start = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("held_start.init",    32'(init),    32'd0);
      check("held_start.running", 32'(running), 32'd0);
    end
    start = 1'b0;
    @(posedge clk);
    #1;

    // Boundary run lengths and randomized runs; each accept must clear bist_end.
    run_bist(1, 2'b10, 0, 0);
    run_bist(2, 2'b00, 0, 0);
    run_bist(1023, 2'b00, 0, 0);
    repeat (8) begin
      run_bist($urandom_range(1, 40), NPASS'($urandom), 0, 0);
    end

`ifdef BIST_ABORT_EN
    // Abort at pass 1 RUN cnt=1 (cfg=6).
    run_bist(6, 2'b00, 0, 2 + (6 + 2) + 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
